// File: rtl/present_pkg.sv
// ==== present_pkg : PRESENT-80 key-schedule widths, S-boxes and key-register state codes ====
// rev 1.0
`default_nettype none

package present_pkg;

    localparam int KEY_W = 80;
    localparam int RC_W  = 5;
    localparam int RK_W  = 64;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
        endcase
        return y;
    endfunction

endpackage

`default_nettype wire

// File: rtl/kreg_inv_if.sv
// ==== kreg_inv_if : control/key bus of the decryption key register (ldl with KREG_INV_DIRECT_EN) ====
// rev 1.0
`default_nettype none

interface kreg_inv_if;
    logic                          sta;
    logic [0:present_pkg::KEY_W-1] inp;
    logic                          act;
`ifdef KREG_INV_DIRECT_EN
    logic                          ldl;
`endif
    logic [0:present_pkg::KEY_W-1] out;
    logic [0:present_pkg::RC_W-1]  rnd;
    logic                          rdy;
    logic                          bsy;

`ifdef KREG_INV_DIRECT_EN
    modport master (output sta, inp, act, ldl, input out, rnd, rdy, bsy);
    modport slave  (input sta, inp, act, ldl, output out, rnd, rdy, bsy);
`else
    modport master (output sta, inp, act, input out, rnd, rdy, bsy);
    modport slave  (input sta, inp, act, output out, rnd, rdy, bsy);
`endif
endinterface

`default_nettype wire

// File: rtl/kreg_inv_kupd.sv
// ==== kreg_inv_kupd : combinational PRESENT-80 key update, forward F (i_inv=0) or inverse G (i_inv=1) ====
// rev 1.0
`default_nettype none

module kreg_inv_kupd
    import present_pkg::*;
(
    input  logic [KEY_W-1:0] i_key,
    input  logic [RC_W-1:0]  i_rc,
    input  logic             i_inv,
    output logic [KEY_W-1:0] o_key
);

    logic [KEY_W-1:0] w_pre;
    logic [KEY_W-1:0] w_mid;
    logic [3:0]       w_nib;

    // Nibble 79..76 and counter field 19..15 are disjoint, so one substitution stage serves both directions
    always_comb begin
        w_pre = i_inv ? i_key : {i_key[18:0], i_key[79:19]};
        w_nib = i_inv ? sbox_inv(w_pre[79:76]) : sbox(w_pre[79:76]);
        w_mid = {w_nib, w_pre[75:20], w_pre[19:15] ^ i_rc, w_pre[14:0]};
        o_key = i_inv ? {w_mid[60:0], w_mid[79:61]} : w_mid;
    end

endmodule

`default_nettype wire

// File: rtl/kreg_inv.sv
// ==== kreg_inv : PRESENT-80 decryption key register, round keys RK32..RK1 (KREG_INV_DIRECT_EN: direct K_last load) ====
// rev 1.0
`default_nettype none

module kreg_inv
    import present_pkg::*;
#(
    parameter int ROUNDS = 31
)(
    input  wire logic  ck,
    input  wire logic  rst,
    kreg_inv_if.slave  bus
);

    localparam logic [RC_W-1:0] C_ROUNDS = RC_W'(ROUNDS);

    logic [KEY_W-1:0] r_key;
    logic [RC_W-1:0]  r_rnd;
    logic [1:0]       r_state;
    logic             r_rdy;
    logic             r_bsy;
    logic [KEY_W-1:0] w_upd;
    logic             w_direct;

`ifdef KREG_INV_DIRECT_EN
    assign w_direct = bus.ldl;
`else
    assign w_direct = 1'b0;
`endif

    kreg_inv_kupd u_kupd (
        .i_key (r_key),
        .i_rc  (r_rnd),
        .i_inv (r_state == ST_RUN),
        .o_key (w_upd)
    );

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_key   <= '0;
            r_rnd   <= '0;
            r_state <= ST_IDLE;
            r_rdy   <= 1'b0;
            r_bsy   <= 1'b0;
        end else if (bus.sta) begin
            r_key <= bus.inp;
            if (w_direct) begin
                r_rnd   <= C_ROUNDS;
                r_state <= ST_RUN;
                r_rdy   <= 1'b1;
                r_bsy   <= 1'b0;
            end else begin
                r_rnd   <= RC_W'(1);
                r_state <= ST_PRE;
                r_rdy   <= 1'b0;
                r_bsy   <= 1'b1;
            end
        end else begin
            case (r_state)
                ST_PRE: begin
                    r_key <= w_upd;
                    if (r_rnd < C_ROUNDS) begin
                        r_rnd <= r_rnd + RC_W'(1);
                    end else begin
                        r_state <= ST_RUN;
                        r_rdy   <= 1'b1;
                        r_bsy   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // rnd=0 means out already holds K1; further steps are dropped
                    if (bus.act && (r_rnd != '0)) begin
                        r_key <= w_upd;
                        r_rnd <= r_rnd - RC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out = r_key;
    assign bus.rnd = r_rnd;
    assign bus.rdy = r_rdy;
    assign bus.bsy = r_bsy;

endmodule

`default_nettype wire

// File: tb/tb_kreg_inv.sv
// ==== tb_kreg_inv : scoreboard bench for kreg_inv (ROUNDS=1 and ROUNDS=31 instances) ====
// rev 1.0
`default_nettype none

module tb_kreg_inv;

    logic ck = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 ck = ~ck;
    always @(posedge ck) cyc <= cyc + 1;

    kreg_inv_if if1 ();
    kreg_inv_if if31 ();

    kreg_inv #(.ROUNDS(1))  u_dut1  (.ck(ck), .rst(rst), .bus(if1));
    kreg_inv #(.ROUNDS(31)) u_dut31 (.ck(ck), .rst(rst), .bus(if31));

    localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                         4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    // Reference forward key update straight from the PRESENT key schedule
    function automatic logic [79:0] f_ref(input logic [79:0] k, input int c);
        logic [79:0] t;
        t = (k << 61) | (k >> 19);
        t[79:76] = SBOX[t[79:76]];
        t = t ^ (80'(c & 31) << 15);
        return t;
    endfunction

    logic [79:0] kf [1:33];

    task automatic build_keys(input logic [79:0] k1);
        kf[1] = k1;
        for (int j = 1; j <= 32; j++) kf[j+1] = f_ref(kf[j], j);
    endtask

    typedef struct {
        int          cyc;
        int          dut;
        logic [79:0] o;
        logic [4:0]  r;
        logic        rdy;
        logic        bsy;
        string       nm;
    } exp_t;

    exp_t sb[$];

    task automatic push_exp(input int d, input int dut, input logic [79:0] o, input int r,
                            input logic rdy, input logic bsy, input string nm);
        exp_t e;
        e.cyc = cyc + d; e.dut = dut; e.o = o; e.r = 5'(r);
        e.rdy = rdy; e.bsy = bsy; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic check(input exp_t e);
        logic [79:0] ao;
        logic [4:0]  ar;
        logic        ardy, absy;
        if (e.dut == 0) begin
            ao = if1.out; ar = if1.rnd; ardy = if1.rdy; absy = if1.bsy;
        end else begin
            ao = if31.out; ar = if31.rnd; ardy = if31.rdy; absy = if31.bsy;
        end
        n_chk++;
        if ({ao, ar, ardy, absy} === {e.o, e.r, e.rdy, e.bsy}) n_pass++;
        else $display("FAIL %s cyc=%0d dut=%0d got out=%h rnd=%0d rdy=%b bsy=%b want out=%h rnd=%0d rdy=%b bsy=%b",
                      e.nm, cyc, e.dut, ao, ar, ardy, absy, e.o, e.r, e.rdy, e.bsy);
    endtask

    always @(negedge ck) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                check(sb[i]);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    // Precompute trace for n cycles after the sta edge, keys taken from kf
    task automatic sched_pre(input int dut, input int r, input int n);
        for (int k = 0; k < n; k++)
            push_exp(1 + k, dut, kf[k+1], (k + 1 < r) ? k + 1 : r, k == r, k < r, "pre");
    endtask

    function automatic logic [79:0] rand80();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[79:0];
    endfunction

    logic [79:0] key;

    initial begin
        if1.sta = 0;  if1.act = 0;  if1.inp = '0;
        if31.sta = 0; if31.act = 0; if31.inp = '0;
`ifdef KREG_INV_DIRECT_EN
        if1.ldl = 0;  if31.ldl = 0;
`endif
        step(); step();
        rst = 0;
        push_exp(0, 0, 80'h0, 0, 0, 0, "reset1");
        push_exp(0, 1, 80'h0, 0, 0, 0, "reset31");

        // ROUNDS=1 with zero key
        step();
        if1.inp = '0; if1.sta = 1;
        push_exp(1, 0, 80'h0, 1, 0, 1, "r1_load");
        push_exp(2, 0, 80'hC0000000000000008000, 1, 1, 0, "r1_k2");
        step(); if1.sta = 0;
        step();
        if1.act = 1;
        push_exp(1, 0, 80'h0, 0, 1, 0, "r1_inv");
        step(); if1.act = 0;

        // ROUNDS=31 full precompute, 31 inverse steps, then hold at rnd=0
        step();
        key = rand80();
        build_keys(key);
        if31.inp = key; if31.sta = 1;
        sched_pre(1, 31, 32);
        step(); if31.sta = 0;
        repeat (31) step();
        if31.act = 1;
        for (int d = 1; d <= 31; d++) push_exp(d, 1, kf[32-d], 31 - d, 1, 0, "inv_seq");
        for (int d = 32; d <= 35; d++) push_exp(d, 1, key, 0, 1, 0, "hold_rnd0");
        repeat (35) step();

        // sta with act in RUN restarts; reset arrives mid-precompute
        key = rand80();
        build_keys(key);
        if31.inp = key; if31.sta = 1; if31.act = 1;
        sched_pre(1, 31, 5);
        step(); if31.sta = 0; if31.act = 0;
        repeat (4) step();
        @(negedge ck);
        #3 rst = 1;
        #1;
        n_chk++;
        if ({if31.out, if31.rnd, if31.rdy, if31.bsy} === 87'h0) n_pass++;
        else $display("FAIL async_reset got out=%h rnd=%0d rdy=%b bsy=%b want all zero",
                      if31.out, if31.rnd, if31.rdy, if31.bsy);
        step(); step();
        rst = 0;
        repeat (3) step();
        push_exp(0, 1, 80'h0, 0, 0, 0, "idle_after_rst");
        push_exp(0, 0, 80'h0, 0, 0, 0, "idle_after_rst1");

`ifdef KREG_INV_DIRECT_EN
        step();
        key = rand80();
        build_keys(key);
        if31.inp = kf[32]; if31.sta = 1; if31.ldl = 1;
        push_exp(1, 1, kf[32], 31, 1, 0, "direct_load");
        step(); if31.sta = 0; if31.ldl = 0;
        if31.act = 1;
        for (int d = 1; d <= 31; d++) push_exp(d, 1, kf[32-d], 31 - d, 1, 0, "direct_inv");
        repeat (31) step();
        if31.act = 0;
`endif

        repeat (3) step();
        while (sb.size() > 0) begin
            n_chk++;
            $display("FAIL %s never checked: due cyc=%0d now %0d", sb[0].nm, sb[0].cyc, cyc);
            void'(sb.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
